row_shift_pipe: RTL
===================

# row_shift_pipe

Parametrised, pipelined ShiftRows / InvShiftRows stage for the Rijndael datapath. It accepts a Rijndael state of NB columns and permutes each row cyclically by the standard per-row offsets. The direction is selected per transfer, so one instance serves both the encryption and decryption round pipelines. Both sides use valid/ready handshakes, and a sideband tag travels with each state so the round controller can track in-flight blocks.

## Interface
- NB, 4: state columns; legal values 4, 6, 8 (block width BW = 32·NB bits).
- TAG_W, 4: sideband tag width, ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept an input beat.
- in_data  in  BW  input state.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  BW  permuted state.
- out_tag  out  TAG_W  tag of out_data.
- out_inv  out  1  direction used for out_data.

## Operation
- Byte layout is column-major, MSB first: byte k = r + 4c occupies in_data[BW-1-8k -: 8] (row r 0..3, column c 0..NB-1).
- Row offsets s(r):
  - NB=4 or NB=6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c − s(r)) mod NB], with the modulus taken non-negative.
- Row 0 is never moved. The inverse of the forward output restores the original state bit-exactly.
- The permutation is applied combinationally on the input side. It is captured in the output register, together with the tag and the inv bit, on the input handshake (in_valid && in_ready).
- Output register:
  - Loads on the input handshake.
  - out_valid clears on an output handshake (out_valid && out_ready) with no simultaneous load.
  - Simultaneous load and unload: the register takes the new beat and out_valid stays 1.
- While out_valid=1 and out_ready=0, out_data, out_tag and out_inv hold stable.
- in_data, in_inv and in_tag are ignored when in_valid=0.
- Illegal NB is rejected at elaboration (fatal).

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- Reset: out_valid=0, out_data=0, out_tag=0, out_inv=0.
  - in_ready=0 during the reset cycle and 1 from the first cycle after reset is released.
  - A beat in flight when rst is asserted is discarded; no partial output is produced.
- in_ready without skid buffering is combinational: in_ready = out_ready || !out_valid.

## Configuration
- ROW_SHIFT_SKID_EN defined:
  - Adds a one-entry skid register behind the output register.
  - in_ready is driven directly from a flop: in_ready = !skid_valid, with no combinational path from out_ready.
  - A beat accepted while the output register is stalled goes to the skid register. When the output register drains, the skid register moves into it, preserving order.
  - Latency is still 1 cycle when not stalled.
  - Reset clears skid_valid.
- ROW_SHIFT_SKID_EN undefined: single output register with combinational in_ready as above.

## Structure
- aes_pkg holds:
  - The row offset function row_offset(nb, r).
  - The mode encoding constants MODE_FWD=0 and MODE_INV=1.
  - The legal-NB check function.
- Sub-module row_shift_perm: purely combinational permutation.
  - Parameter NB; ports data_i, inv_i, data_o.
  - Instantiated once, ahead of the output register.
- row_shift_pipe contains only the handshake, output and skid registers, and the tag/inv pipeline.

## Test plan
- NB=4, forward, in_data=0xd42711aee0bf98f1b8b45de51e415230 → out_data=0xd4bf5d30e0b452aeb84111f11e2798e5 one cycle later, with out_tag equal to in_tag.
- NB=4, inverse, in_data=0xd4bf5d30e0b452aeb84111f11e2798e5 → out_data=0xd42711aee0bf98f1b8b45de51e415230, out_inv=1.
- NB=8: input byte k equals k (0x00..0x1f) → check forward offsets 0/1/3/4 against a reference model; then apply forward followed by inverse and check the original state is restored. Repeat for NB=6.
- Back-to-back stream of 16 beats, tags 0..15, alternating in_inv, out_ready=1 → 16 outputs in order, one per cycle, each with the correct direction.
- Back-pressure: hold out_ready=0 for 5 cycles mid-stream.
  - out_* stay stable throughout the stall.
  - No beat is lost or duplicated.
  - With ROW_SHIFT_SKID_EN, exactly one extra beat is accepted and then in_ready=0.
- Assert rst while out_valid=1 → the next cycle shows out_valid=0 and out_data=0; no stale beat ever appears after reset.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael datapath definitions: direction encoding, row offsets, legal NB check.
package aes_pkg;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } mode_e;

    // Rows 2 and 3 shift one extra position for 8-column states.
    function automatic int unsigned row_offset(input int unsigned nb, input int unsigned r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    function automatic bit nb_is_legal(input int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/row_shift_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation over an NB-column state.
module row_shift_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] data_i,
    input  logic             inv_i,
    output logic [32*NB-1:0] data_o
);
    localparam int unsigned BW = 32 * NB;

    // Byte k = r + 4c sits at data[BW-1-8k -: 8]; every source index is an elaboration constant.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int unsigned S       = row_offset(NB, r);
            localparam int unsigned SRC_FWD = (c + S) % NB;
            localparam int unsigned SRC_INV = (c + NB - S) % NB;
            assign data_o[BW-1-8*(r+4*c) -: 8] = (inv_i == MODE_INV)
                ? data_i[BW-1-8*(r+4*SRC_INV) -: 8]
                : data_i[BW-1-8*(r+4*SRC_FWD) -: 8];
        end
    end

endmodule

// File: rtl/row_shift_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage with valid/ready handshake and tag sideband.
// Define ROW_SHIFT_SKID_EN for a flop-driven in_ready backed by a one-entry skid register.
module row_shift_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_inv
);
    localparam int unsigned BW = 32 * NB;

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $fatal(1, "row_shift_pipe: NB must be 4, 6 or 8");
    end

    logic [BW-1:0] perm_data;

    row_shift_perm #(.NB(NB)) u_perm (
        .data_i (in_data),
        .inv_i  (in_inv),
        .data_o (perm_data)
    );

    logic             out_valid_q, out_valid_d;
    logic [BW-1:0]    out_data_q,  out_data_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             out_inv_q,   out_inv_d;
    logic             in_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_inv   = out_inv_q;

`ifdef ROW_SHIFT_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [BW-1:0]    skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_inv_q,   skid_inv_d;
    logic             out_free;

    assign in_ready = !rst && !skid_valid_q;
    assign out_free = !out_valid_q || out_ready;

    // in_ready is low whenever the skid holds a beat, so a refill from skid never races a new input.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_inv_d    = out_inv_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_inv_d   = skid_inv_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                out_inv_d    = skid_inv_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = perm_data;
                out_tag_d   = in_tag;
                out_inv_d   = in_inv;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm_data;
            skid_tag_d   = in_tag;
            skid_inv_d   = in_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_inv_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_inv_q   <= skid_inv_d;
        end
    end
`else
    assign in_ready = !rst && (out_ready || !out_valid_q);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_inv_d   = out_inv_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = perm_data;
            out_tag_d   = in_tag;
            out_inv_d   = in_inv;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_inv_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_inv_q   <= out_inv_d;
        end
    end

endmodule
